dsp_mac_job_sequencer: RTL and testbench
========================================

// Module: dsp_mac_job_sequencer
// PURPOSE
//  Sequences one accumulate-shift-round DSP slice (A*B into a P accumulator) through dot-product jobs.
//  A job is a config handshake (length, add/subtract, shift, round), then LEN operand beats, then one result handshake.
//  The sequencer drives the DSP control pins and captures the shifted/rounded P once the pipeline drains.
//  It sits between a stream producer and the DSP instance, which is instantiated by the parent.
// PARAMETERS
//  A_W      20  width of signed operand A
//  B_W      18  width of signed operand B
//  P_W      64  width of DSP result P
//  LEN_W    8   width of job length field (max 2**LEN_W-1 beats)
//  DSP_LAT  2   clk cycles from registered dsp_* inputs to dsp_p valid (negedge-capturing slice: 2)
// PORTS
//  clk             in   1      single clock, all sequencer flops on posedge
//  reset           in   1      asynchronous, active-low
//  cfg_valid       in   1      job config offered
//  cfg_ready       out  1      config accepted (IDLE only)
//  cfg_len         in   LEN_W  number of operand beats
//  cfg_subtract    in   1      1: P -= A*B, 0: P += A*B
//  cfg_shift       in   6      output right-shift amount
//  cfg_round       in   1      round-half-up on shifted output
//  in_valid        in   1      operand beat offered
//  in_ready        out  1      operand beat accepted (RUN only)
//  in_a            in   A_W    signed operand A
//  in_b            in   B_W    signed operand B
//  dsp_reset       out  1      active-high clear to DSP
//  dsp_load_acc    out  1      DSP accumulate enable
//  dsp_subtract    out  1      to DSP subtract_i
//  dsp_shift_right out  6      to DSP shift_right_i
//  dsp_round       out  1      to DSP round_i
//  dsp_a           out  A_W    to DSP A
//  dsp_b           out  B_W    to DSP B
//  dsp_p           in   P_W    from DSP P
//  res_valid       out  1      result available
//  res_ready       in   1      result consumed
//  res_data        out  P_W    captured P
//  busy            out  1      state != IDLE
// BEHAVIOUR
//  Reset values (async, reset=0):
//   - state IDLE; dsp_reset=1, so the DSP stays cleared while in reset.
//   - all other outputs 0, except cfg_ready=1.
//  All outputs are registered.
//  FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
//  IDLE:
//   - cfg_ready=1; dsp_load_acc=0.
//   - On cfg_valid&cfg_ready: latch cfg_*, go to CLEAR.
//  Static config: dsp_subtract, dsp_shift_right and dsp_round follow the latched cfg from the CLEAR cycle until the next job. They never change mid-job.
//  CLEAR:
//   - dsp_reset=1 for exactly one cycle.
//   - beat counter <= cfg_len.
//   - Next state: RUN if cfg_len!=0, else DRAIN.
//  RUN:
//   - in_ready=1 while the counter is nonzero.
//   - On an accepted beat at edge k: dsp_a/dsp_b <= in_a/in_b and dsp_load_acc <= 1 for the cycle after k; counter decrements.
//   - Bubble (no beat accepted): dsp_load_acc <= 0, dsp_a/dsp_b <= 0. The accumulator holds.
//   - Last beat accepted: next state DRAIN, in_ready drops the next cycle; no extra beat is ever taken.
//  DRAIN:
//   - dsp_load_acc=0; count DSP_LAT+1 cycles.
//   - On the final drain edge: res_data <= dsp_p, res_valid <= 1, go to DONE.
//  DONE:
//   - res_valid=1; res_data is stable until res_valid&res_ready.
//   - On that handshake: go to IDLE, res_valid=0.
//   - cfg is not accepted in DONE; a new job starts one cycle after the result handshake at the earliest.
//  Latency: res_valid rises DSP_LAT+2 edges after the last in handshake.
//  cfg_len=0: result equals the cleared DSP output, 0.
//  Arithmetic is done entirely by the DSP. The sequencer never modifies dsp_p (no sign extension or truncation).
//  Reset asserted mid-job: immediate return to IDLE; the partial result is discarded and dsp_reset=1.
// STRUCTURE
//  Package dsp_seq_pkg holds:
//   - state enum seq_state_t {IDLE, CLEAR, RUN, DRAIN, DONE};
//   - the shift field width constant (6);
//   - default A_W, B_W and P_W constants.
//  No sub-module: FSM, beat counter and drain counter live in one module. The DSP is instantiated by the parent or the bench.
// TESTING
//  Bench instantiates the sequencer plus the real DSP slice. Every check compares against a 64-bit software model.
//  1. add, len=1, A=5, B=2, shift=0, round=0 -> res_data=10; res_valid exactly DSP_LAT+2 edges after the beat.
//  2. subtract, len=4, beats (5,2),(-3,7),(100,-1),(0,9) -> res_data=-10+21+100+0=111.
//  3. add, len=1, A=5, B=4, shift=3 -> round=0: 2; round=1: 3. Then A=8, B=7, shift=3, round=1 -> 7.
//  4. len=3 beats (1,1),(2,2),(3,3) with in_valid toggling every other cycle -> 14; exactly 3 beats accepted.
//     Same job with res_ready held low 5 cycles -> res_data stable, cfg_ready=0 throughout.
//  5. Edge cases:
//     - len=0 -> res_data=0 after CLEAR+DRAIN.
//     - reset pulsed low in RUN after 2 of 4 beats -> IDLE, dsp_reset=1, no res_valid; next job (A=5, B=2, len=1) -> 10.

Source files
------------

// File: rtl/dsp_seq_pkg.sv
// Shared types and constants for the DSP MAC job sequencer.
package dsp_seq_pkg;

  localparam int SHIFT_W   = 6;
  localparam int A_W_DEF   = 20;
  localparam int B_W_DEF   = 18;
  localparam int P_W_DEF   = 64;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

endpackage

// File: rtl/dsp_mac_job_sequencer.sv
// Drives an external accumulate-shift-round DSP slice through dot-product jobs:
// config handshake, LEN operand beats, pipeline drain, result handshake.
module dsp_mac_job_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int A_W     = A_W_DEF,
  parameter int B_W     = B_W_DEF,
  parameter int P_W     = P_W_DEF,
  parameter int LEN_W   = 8,
  parameter int DSP_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_subtract,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_round,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  output logic               dsp_reset,
  output logic               dsp_load_acc,
  output logic               dsp_subtract,
  output logic [SHIFT_W-1:0] dsp_shift_right,
  output logic               dsp_round,
  output logic [A_W-1:0]     dsp_a,
  output logic [B_W-1:0]     dsp_b,
  input  logic [P_W-1:0]     dsp_p,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [P_W-1:0]     res_data,
  output logic               busy
);

  localparam int DRAIN_W = $clog2(DSP_LAT + 2);

  seq_state_t         state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               in_ready_q, in_ready_d;
  logic               dsp_reset_q, dsp_reset_d;
  logic               dsp_load_acc_q, dsp_load_acc_d;
  logic               dsp_subtract_q, dsp_subtract_d;
  logic [SHIFT_W-1:0] dsp_shift_q, dsp_shift_d;
  logic               dsp_round_q, dsp_round_d;
  logic [A_W-1:0]     dsp_a_q, dsp_a_d;
  logic [B_W-1:0]     dsp_b_q, dsp_b_d;
  logic               res_valid_q, res_valid_d;
  logic [P_W-1:0]     res_data_q, res_data_d;
  logic               busy_q, busy_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d        = state_q;
    cnt_d          = cnt_q;
    cfg_len_d      = cfg_len_q;
    drain_d        = drain_q;
    dsp_load_acc_d = 1'b0;
    dsp_subtract_d = dsp_subtract_q;
    dsp_shift_d    = dsp_shift_q;
    dsp_round_d    = dsp_round_q;
    dsp_a_d        = '0;
    dsp_b_d        = '0;
    res_valid_d    = res_valid_q;
    res_data_d     = res_data_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          cfg_len_d      = cfg_len;
          dsp_subtract_d = cfg_subtract;
          dsp_shift_d    = cfg_shift;
          dsp_round_d    = cfg_round;
          state_d        = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d = cfg_len_q;
        if (cfg_len_q != '0) begin
          state_d = RUN;
        end else begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(DSP_LAT);
        end
      end
      RUN: begin
        if (in_valid && in_ready_q) begin
          dsp_a_d        = in_a;
          dsp_b_d        = in_b;
          dsp_load_acc_d = 1'b1;
          cnt_d          = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = DRAIN;
            drain_d = DRAIN_W'(DSP_LAT);
          end
        end
      end
      DRAIN: begin
        // Down-counts DSP_LAT..0, i.e. DSP_LAT+1 cycles, before sampling P.
        if (drain_q == '0) begin
          res_data_d  = dsp_p;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake/status outputs are registered, so derive them from the next state.
    cfg_ready_d = (state_d == IDLE);
    in_ready_d  = (state_d == RUN) && (cnt_d != '0);
    dsp_reset_d = (state_d == CLEAR);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cfg_len_q      <= '0;
      drain_q        <= '0;
      cfg_ready_q    <= 1'b1;
      in_ready_q     <= 1'b0;
      dsp_reset_q    <= 1'b1;
      dsp_load_acc_q <= 1'b0;
      dsp_subtract_q <= 1'b0;
      dsp_shift_q    <= '0;
      dsp_round_q    <= 1'b0;
      dsp_a_q        <= '0;
      dsp_b_q        <= '0;
      res_valid_q    <= 1'b0;
      res_data_q     <= '0;
      busy_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cfg_len_q      <= cfg_len_d;
      drain_q        <= drain_d;
      cfg_ready_q    <= cfg_ready_d;
      in_ready_q     <= in_ready_d;
      dsp_reset_q    <= dsp_reset_d;
      dsp_load_acc_q <= dsp_load_acc_d;
      dsp_subtract_q <= dsp_subtract_d;
      dsp_shift_q    <= dsp_shift_d;
      dsp_round_q    <= dsp_round_d;
      dsp_a_q        <= dsp_a_d;
      dsp_b_q        <= dsp_b_d;
      res_valid_q    <= res_valid_d;
      res_data_q     <= res_data_d;
      busy_q         <= busy_d;
    end
  end

  assign cfg_ready       = cfg_ready_q;
  assign in_ready        = in_ready_q;
  assign dsp_reset       = dsp_reset_q;
  assign dsp_load_acc    = dsp_load_acc_q;
  assign dsp_subtract    = dsp_subtract_q;
  assign dsp_shift_right = dsp_shift_q;
  assign dsp_round       = dsp_round_q;
  assign dsp_a           = dsp_a_q;
  assign dsp_b           = dsp_b_q;
  assign res_valid       = res_valid_q;
  assign res_data        = res_data_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_dsp_mac_job_sequencer.sv
// Bench for dsp_mac_job_sequencer with a behavioural negedge-accumulating DSP slice
// (two-cycle P latency) attached to its control pins.
module tb_dsp_mac_job_sequencer;

  localparam int A_W = 20;
  localparam int B_W = 18;
  localparam int P_W = 64;
  localparam int LEN_W = 8;
  localparam int DSP_LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_valid = 1'b0, cfg_ready;
  logic [LEN_W-1:0] cfg_len = '0;
  logic cfg_subtract = 1'b0, cfg_round = 1'b0;
  logic [5:0] cfg_shift = '0;
  logic in_valid = 1'b0, in_ready;
  logic [A_W-1:0] in_a = '0;
  logic [B_W-1:0] in_b = '0;
  logic dsp_reset, dsp_load_acc, dsp_subtract, dsp_round;
  logic [5:0] dsp_shift_right;
  logic [A_W-1:0] dsp_a;
  logic [B_W-1:0] dsp_b;
  logic [P_W-1:0] dsp_p;
  logic res_valid, res_ready = 1'b0, busy;
  logic [P_W-1:0] res_data;

  int n_total = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dsp_mac_job_sequencer #(
    .A_W(A_W), .B_W(B_W), .P_W(P_W), .LEN_W(LEN_W), .DSP_LAT(DSP_LAT)
  ) dut (
    .clk(clk), .reset(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_len(cfg_len),
    .cfg_subtract(cfg_subtract), .cfg_shift(cfg_shift), .cfg_round(cfg_round),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_reset(dsp_reset), .dsp_load_acc(dsp_load_acc), .dsp_subtract(dsp_subtract),
    .dsp_shift_right(dsp_shift_right), .dsp_round(dsp_round),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_p(dsp_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  // Behavioural DSP slice: accumulate on negedge, shape, then one output register.
  logic signed [P_W-1:0] acc, st1, prod;
  assign prod = P_W'($signed(dsp_a)) * P_W'($signed(dsp_b));

  function automatic logic signed [P_W-1:0] shape(input logic signed [P_W-1:0] v,
                                                  input logic [5:0] sh, input logic rnd);
    logic signed [P_W-1:0] bias;
    bias = (rnd && sh != 6'd0) ? (P_W'(1) << (sh - 6'd1)) : '0;
    return (v + bias) >>> sh;
  endfunction

  always @(negedge clk) begin
    if (dsp_reset) acc <= '0;
    else if (dsp_load_acc) acc <= dsp_subtract ? acc - prod : acc + prod;
  end

  always @(posedge clk) begin
    st1   <= shape(acc, dsp_shift_right, dsp_round);
    dsp_p <= st1;
  end

  typedef struct {
    string                       name;
    logic [LEN_W-1:0]            len;
    logic                        sub;
    logic [5:0]                  sh;
    logic                        rnd;
    logic [3:0][A_W-1:0]         a;
    logic [3:0][B_W-1:0]         b;
    logic [P_W-1:0]              exp;
  } vec_t;

  task automatic check(input string name, input logic [P_W-1:0] got, input logic [P_W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  task automatic run_job(input vec_t v, input bit toggle, input int hold);
    int budget, acc_n, edges, idx;
    bit phase, took;
    cfg_len = v.len; cfg_subtract = v.sub; cfg_shift = v.sh; cfg_round = v.rnd;
    cfg_valid = 1'b1;
    budget = 0;
    while (!cfg_ready && budget < 20) begin
      @(posedge clk); #1; budget++;
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    check({v.name, "_clear_pulse"}, P_W'(dsp_reset), 1);
    check({v.name, "_busy"}, P_W'(busy), 1);

    acc_n = 0; edges = 0; phase = 1'b1; budget = 0;
    while (!res_valid && budget < 200) begin
      idx = (acc_n < 4) ? acc_n : 0;
      in_valid = toggle ? phase : 1'b1;
      in_a = (acc_n < int'(v.len)) ? v.a[idx] : A_W'(77);
      in_b = (acc_n < int'(v.len)) ? v.b[idx] : B_W'(33);
      took = in_valid && in_ready;
      @(posedge clk); #1;
      phase = ~phase; budget++;
      if (took) begin
        acc_n++;
        edges = 1;
      end else if (edges > 0) begin
        edges++;
      end
    end
    in_valid = 1'b0;
    check({v.name, "_res_valid"}, P_W'(res_valid), 1);
    check({v.name, "_beats"}, P_W'(acc_n), P_W'(v.len));
    // Edges counted from the handshake edge through the edge raising res_valid.
    if (v.len != '0) check({v.name, "_latency"}, P_W'(edges), P_W'(DSP_LAT + 2));
    check({v.name, "_data"}, res_data, v.exp);

    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({v.name, "_hold_data"}, res_data, v.exp);
      check({v.name, "_hold_valid"}, P_W'(res_valid), 1);
      check({v.name, "_hold_cfg_ready"}, P_W'(cfg_ready), 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check({v.name, "_res_dropped"}, P_W'(res_valid), 0);
    check({v.name, "_back_idle"}, P_W'(cfg_ready), 1);
  endtask

  vec_t vecs[6];
  vec_t tri_job;

  initial begin
    int acc_n, budget, seen;
    bit took;

    vecs[0] = '{"add1", 8'd1, 1'b0, 6'd0, 1'b0, {20'sd0, 20'sd0, 20'sd0, 20'sd5},
                {18'sd0, 18'sd0, 18'sd0, 18'sd2}, 64'sd10};
    vecs[1] = '{"sub4", 8'd4, 1'b1, 6'd0, 1'b0, {20'sd0, 20'sd100, -20'sd3, 20'sd5},
                {18'sd9, -18'sd1, 18'sd7, 18'sd2}, 64'sd111};
    vecs[2] = '{"shr_trunc", 8'd1, 1'b0, 6'd3, 1'b0, {20'sd0, 20'sd0, 20'sd0, 20'sd5},
                {18'sd0, 18'sd0, 18'sd0, 18'sd4}, 64'sd2};
    vecs[3] = '{"shr_round", 8'd1, 1'b0, 6'd3, 1'b1, {20'sd0, 20'sd0, 20'sd0, 20'sd5},
                {18'sd0, 18'sd0, 18'sd0, 18'sd4}, 64'sd3};
    vecs[4] = '{"shr_round_56", 8'd1, 1'b0, 6'd3, 1'b1, {20'sd0, 20'sd0, 20'sd0, 20'sd8},
                {18'sd0, 18'sd0, 18'sd0, 18'sd7}, 64'sd7};
    vecs[5] = '{"len0", 8'd0, 1'b0, 6'd0, 1'b0, {20'sd9, 20'sd9, 20'sd9, 20'sd9},
                {18'sd9, 18'sd9, 18'sd9, 18'sd9}, 64'sd0};
    tri_job = '{"toggle3", 8'd3, 1'b0, 6'd0, 1'b0, {20'sd0, 20'sd3, 20'sd2, 20'sd1},
                {18'sd0, 18'sd3, 18'sd2, 18'sd1}, 64'sd14};

    #22;
    check("rst_dsp_reset", P_W'(dsp_reset), 1);
    check("rst_cfg_ready", P_W'(cfg_ready), 1);
    check("rst_in_ready", P_W'(in_ready), 0);
    check("rst_res_valid", P_W'(res_valid), 0);
    check("rst_busy", P_W'(busy), 0);
    check("rst_load_acc", P_W'(dsp_load_acc), 0);
    check("rst_res_data", res_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_job(vecs[i], 1'b0, 0);

    run_job(tri_job, 1'b1, 0);
    tri_job.name = "toggle3_hold";
    run_job(tri_job, 1'b1, 5);

    // Reset mid-job after two of four beats.
    cfg_len = 8'd4; cfg_subtract = 1'b0; cfg_shift = '0; cfg_round = 1'b0;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    acc_n = 0; budget = 0;
    while (acc_n < 2 && budget < 20) begin
      in_valid = 1'b1; in_a = A_W'(6); in_b = B_W'(6);
      took = in_ready;
      @(posedge clk); #1;
      budget++;
      if (took) acc_n++;
    end
    in_valid = 1'b0;
    check("midjob_beats", P_W'(acc_n), 2);
    #2 rst_n = 1'b0;
    #1;
    check("midjob_dsp_reset", P_W'(dsp_reset), 1);
    check("midjob_busy", P_W'(busy), 0);
    check("midjob_cfg_ready", P_W'(cfg_ready), 1);
    check("midjob_in_ready", P_W'(in_ready), 0);
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    check("midjob_no_result", P_W'(seen), 0);
    vecs[0].name = "after_reset";
    run_job(vecs[0], 1'b0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
